// File: rtl/lcd_pkg.sv
// Shared encodings, command bytes and driver state for the 1602A LCD path.
// Consumed by the controller FSM and by lcd_nibble_driver.
package lcd_pkg;

    localparam logic [1:0] EXTERNAL_DATA = 2'b10;
    localparam logic [1:0] INTERNAL_CMD  = 2'b01;
    localparam logic [1:0] UNUSED_DATA   = 2'b00;

    localparam logic [7:0] SETUP      = 8'h28;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] DISP_OFF   = 8'h08;
    localparam logic [7:0] CLEAR_CMD  = 8'h01;
    localparam logic [7:0] HOME       = 8'h02;
    localparam logic [7:0] ENTRY_MODE = 8'h06;

    localparam int REARM_CYC = 2;

    typedef enum logic [2:0] {
        DRV_IDLE,
        DRV_SETUP,
        DRV_PULSE,
        DRV_HOLD,
        DRV_GAP,
        DRV_EXEC,
        DRV_DONE,
        DRV_REARM
    } drv_state_e;

    function automatic logic is_xfer_sel(input logic [1:0] sel);
        return (sel == EXTERNAL_DATA) || (sel == INTERNAL_CMD);
    endfunction

    // Clear and return-home need the long execution wait.
    function automatic logic is_long_cmd(input logic [7:0] b);
        return (b == 8'h01) || (b == 8'h02) || (b == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter used to time each phase of an LCD bus transfer.
module lcd_delay_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_driver.sv
// 4-bit bus driver for the 1602A LCD: nibble split, E strobe timing, exec wait.
// Define LCD_LONG_CMD_EN to use T_LONG for clear/home commands.
module lcd_nibble_driver
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 13,
    parameter int T_HOLD  = 1,
    parameter int T_GAP   = 50,
    parameter int T_EXEC  = 2100,
    parameter int T_LONG  = 82000,
    parameter int CNT_W   = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ctrl_enable_driver,
    input  logic [1:0] ctrl_sel_data,
    input  logic [7:0] ctrl_cmd,
    input  logic [7:0] ext_data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_db,
    output logic       driver_rdy,
    output logic       busy
);

    drv_state_e       state_q;
    logic             nib_q;
    logic [7:0]       byte_q;
    logic             rs_q;
    logic             lcd_e_q;
    logic             lcd_rs_q;
    logic [3:0]       lcd_db_q;
    logic             rdy_q;
    logic             busy_q;

    logic             cap;
    logic             cap_rs;
    logic [7:0]       cap_byte;
    logic             long_cmd;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    lcd_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .zero_o  (tmr_zero)
    );

    always_comb begin
        cap      = (state_q == DRV_IDLE) && ctrl_enable_driver
                   && is_xfer_sel(ctrl_sel_data);
        cap_rs   = (ctrl_sel_data == EXTERNAL_DATA);
        cap_byte = cap_rs ? ext_data : ctrl_cmd;
`ifdef LCD_LONG_CMD_EN
        long_cmd = !rs_q && is_long_cmd(byte_q);
`else
        long_cmd = 1'b0;
`endif
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            DRV_IDLE: begin
                tmr_load = cap;
                tmr_val  = CNT_W'(T_SETUP - 1);
            end
            DRV_SETUP: begin
                tmr_load = tmr_zero;
                tmr_val  = CNT_W'(T_PULSE - 1);
            end
            DRV_PULSE: begin
                tmr_load = tmr_zero;
                tmr_val  = CNT_W'(T_HOLD - 1);
            end
            DRV_HOLD: begin
                tmr_load = tmr_zero;
                if (!nib_q) begin
                    tmr_val = CNT_W'(T_GAP - 1);
                end else if (long_cmd) begin
                    tmr_val = CNT_W'(T_LONG - 1);
                end else begin
                    tmr_val = CNT_W'(T_EXEC - 1);
                end
            end
            DRV_GAP: begin
                tmr_load = tmr_zero;
                tmr_val  = CNT_W'(T_SETUP - 1);
            end
            DRV_DONE: begin
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(REARM_CYC - 1);
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    // Outputs are set on the edge that enters each state, so they stay registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= DRV_IDLE;
            nib_q    <= 1'b0;
            byte_q   <= '0;
            rs_q     <= 1'b0;
            lcd_e_q  <= 1'b0;
            lcd_rs_q <= 1'b0;
            lcd_db_q <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                DRV_IDLE: begin
                    if (cap) begin
                        state_q  <= DRV_SETUP;
                        nib_q    <= 1'b0;
                        byte_q   <= cap_byte;
                        rs_q     <= cap_rs;
                        lcd_rs_q <= cap_rs;
                        lcd_db_q <= cap_byte[7:4];
                        busy_q   <= 1'b1;
                    end
                end
                DRV_SETUP: begin
                    if (tmr_zero) begin
                        state_q <= DRV_PULSE;
                        lcd_e_q <= 1'b1;
                    end
                end
                DRV_PULSE: begin
                    if (tmr_zero) begin
                        state_q <= DRV_HOLD;
                        lcd_e_q <= 1'b0;
                    end
                end
                DRV_HOLD: begin
                    if (tmr_zero) begin
                        state_q  <= nib_q ? DRV_EXEC : DRV_GAP;
                        lcd_db_q <= '0;
                    end
                end
                DRV_GAP: begin
                    if (tmr_zero) begin
                        state_q  <= DRV_SETUP;
                        nib_q    <= 1'b1;
                        lcd_db_q <= byte_q[3:0];
                    end
                end
                DRV_EXEC: begin
                    if (tmr_zero) begin
                        state_q <= DRV_DONE;
                        rdy_q   <= 1'b1;
                    end
                end
                DRV_DONE: begin
                    state_q  <= DRV_REARM;
                    rdy_q    <= 1'b0;
                    busy_q   <= 1'b0;
                    lcd_rs_q <= 1'b0;
                    nib_q    <= 1'b0;
                end
                DRV_REARM: begin
                    if (tmr_zero) begin
                        state_q <= DRV_IDLE;
                    end
                end
                default: begin
                    state_q <= DRV_IDLE;
                end
            endcase
        end
    end

    assign lcd_e      = lcd_e_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_db     = lcd_db_q;
    assign driver_rdy = rdy_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Scoreboard bench for lcd_nibble_driver: random bytes, bus-level monitor.
module tb_lcd_nibble_driver;

    localparam int TS = 2;
    localparam int TP = 13;
    localparam int TH = 1;
    localparam int TG = 50;
    localparam int TE = 2100;
    localparam int TL = 82000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] sel;
    logic [7:0] cmd;
    logic [7:0] dat;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_db;
    logic       driver_rdy;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic       rs;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];

    lcd_nibble_driver dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ctrl_enable_driver (en),
        .ctrl_sel_data      (sel),
        .ctrl_cmd           (cmd),
        .ext_data           (dat),
        .lcd_e              (lcd_e),
        .lcd_rs             (lcd_rs),
        .lcd_rw             (lcd_rw),
        .lcd_db             (lcd_db),
        .driver_rdy         (driver_rdy),
        .busy               (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic rs, input logic [7:0] b);
        int t;
        t = TE;
`ifdef LCD_LONG_CMD_EN
        if (!rs && b >= 8'h01 && b <= 8'h03) t = TL;
`endif
        return 2 * (TS + TP + TH) + TG + t;
    endfunction

    // Monitor: rebuilds each transfer from the pins and checks it on driver_rdy.
    logic       prev_busy = 1'b0;
    logic       prev_e = 1'b0;
    bit         in_xfer = 1'b0;
    int         cap_cyc;
    int         e_cnt;
    int         e_w0;
    int         e_w1;
    int         gap;
    logic [3:0] nib0;
    logic [3:0] nib1;
    logic       rs0;
    logic       rs1;
    exp_t       cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_xfer   = 1'b0;
            prev_busy = 1'b0;
            prev_e    = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                in_xfer = 1'b1;
                cap_cyc = cyc;
                e_cnt   = 0;
                e_w0    = 0;
                e_w1    = 0;
                gap     = 0;
            end
            if (in_xfer) begin
                if (lcd_e && !prev_e) begin
                    if (e_cnt == 0) begin
                        nib0 = lcd_db;
                        rs0  = lcd_rs;
                    end else begin
                        nib1 = lcd_db;
                        rs1  = lcd_rs;
                    end
                    e_cnt++;
                end
                if (lcd_e) begin
                    if (e_cnt == 1) e_w0++;
                    else e_w1++;
                end else if (e_cnt == 1) begin
                    gap++;
                end
            end
            if (driver_rdy) begin
                if (sb.size() == 0 || !in_xfer) begin
                    chk("unexpected_rdy", 32'(sb.size()), 32'hFFFF);
                end else begin
                    cur = sb.pop_front();
                    chk("e_pulses", 32'(e_cnt), 2);
                    chk("byte", {24'h0, nib0, nib1}, {24'h0, cur.b});
                    chk("rs_nib0", 32'(rs0), 32'(cur.rs));
                    chk("rs_nib1", 32'(rs1), 32'(cur.rs));
                    chk("rs_done", 32'(lcd_rs), 32'(cur.rs));
                    chk("busy_done", 32'(busy), 1);
                    chk("rw", 32'(lcd_rw), 0);
                    chk("e_width0", 32'(e_w0), TP);
                    chk("e_width1", 32'(e_w1), TP);
                    chk("e_low_gap", 32'(gap), TS + TH + TG);
                    chk("latency", 32'(cyc - cap_cyc),
                        32'(exp_lat(cur.rs, cur.b)));
                end
                in_xfer = 1'b0;
            end
            prev_busy = busy;
            prev_e    = lcd_e;
        end
    end

    task automatic wait_rdy(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (driver_rdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic xfer(input logic [1:0] s, input logic [7:0] c,
                        input logic [7:0] d, input bit drop, input bit scram);
        exp_t e;
        bit   ok;
        @(negedge clk);
        sel = s;
        cmd = c;
        dat = d;
        en  = 1'b1;
        e.rs = (s == 2'b10);
        e.b  = e.rs ? d : c;
        sb.push_back(e);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("capture", 32'(ok), 1);
        if (drop) en = 1'b0;
        if (scram) begin
            cmd = 8'($urandom);
            dat = 8'($urandom);
            sel = 2'($urandom);
        end
        wait_rdy(exp_lat(e.rs, e.b) + 100, ok);
        chk("rdy_seen", 32'(ok), 1);
        en  = 1'b0;
        sel = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    task automatic back_to_back();
        exp_t e;
        bit   ok;
        int   act;
        @(negedge clk);
        sel = 2'b01;
        cmd = 8'h28;
        en  = 1'b1;
        e.rs = 1'b0;
        e.b  = 8'h28;
        sb.push_back(e);
        e.b = 8'h06;
        sb.push_back(e);
        wait_rdy(exp_lat(1'b0, 8'h28) + 100, ok);
        chk("b2b_rdy1", 32'(ok), 1);
        repeat (2) @(negedge clk);
        cmd = 8'h06;
        wait_rdy(exp_lat(1'b0, 8'h06) + 100, ok);
        chk("b2b_rdy2", 32'(ok), 1);
        @(negedge clk);
        sel = 2'b00;
        act = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (lcd_e || (i > 4 && busy)) act++;
        end
        chk("sel00_idle", 32'(act), 0);
        en = 1'b0;
    endtask

    task automatic reset_mid();
        bit ok;
        @(negedge clk);
        sel = 2'b10;
        dat = 8'($urandom);
        en  = 1'b1;
        ok  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lcd_e) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_e_seen", 32'(ok), 1);
        rst_n = 1'b0;
        en    = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_e", 32'(lcd_e), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rdy", 32'(driver_rdy), 0);
        chk("mid_rst_rs", 32'(lcd_rs), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: cycles %0d limit 150000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] s;
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 2'b00;
        cmd   = 8'h00;
        dat   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_e", 32'(lcd_e), 0);
        chk("rst_rs", 32'(lcd_rs), 0);
        chk("rst_rw", 32'(lcd_rw), 0);
        chk("rst_db", 32'(lcd_db), 0);
        chk("rst_rdy", 32'(driver_rdy), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        xfer(2'b01, 8'h28, 8'($urandom), 1'b0, 1'b0);
        xfer(2'b10, 8'($urandom), 8'h41, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            s = ($urandom % 2 == 0) ? 2'b01 : 2'b10;
            xfer(s, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end
        back_to_back();
        reset_mid();
        xfer(2'b10, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        xfer(2'b01, 8'h01, 8'($urandom), 1'b0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
